// File: rtl/fifo_frame_writer_pkg.sv
// Shared types and helpers for the FIFO frame writer: write-FSM state encoding and a
// constant-evaluable ceil(log2) used to size the frame-length counter.
package fifo_frame_writer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    TRUNC = 2'd2
  } wr_state_e;

  // Number of bits needed to encode 'value' distinct states (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_frame_writer_if.sv
// Bus bundles for the frame writer: the incoming valid/ready word stream and the
// FIFO write port ({last, data} word, write strobe, full flag).
interface fifo_frame_writer_if #(
  parameter int C_WIDTH = 32
);
  logic [C_WIDTH-1:0] S_DATA;
  logic               S_LAST;
  logic               S_VALID;
  logic               S_READY;

  modport master (output S_DATA, S_LAST, S_VALID, input S_READY);
  modport slave  (input S_DATA, S_LAST, S_VALID, output S_READY);
endinterface

interface fifo_wr_port_if #(
  parameter int C_WIDTH = 32
);
  logic [C_WIDTH:0] WR_DATA;
  logic             WR_EN;
  logic             WR_FULL;

  modport master (output WR_DATA, WR_EN, input WR_FULL);
  modport slave  (input WR_DATA, WR_EN, output WR_FULL);
endinterface

// File: rtl/fifo_frame_writer_skid.sv
// Two-entry skid buffer between a valid/ready source and a FIFO write port.
// The out entry drives the FIFO; the skid entry absorbs the word in flight when it stalls.
module fifo_wr_skid
  import fifo_frame_writer_pkg::*;
#(
  parameter int C_DW = 33
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            in_valid,
  input  logic [C_DW-1:0] in_data,
  output logic            in_ready,
  output logic            wr_en,
  output logic [C_DW-1:0] wr_data,
  input  logic            wr_full
);

  logic            out_valid_reg;
  logic            skid_valid_reg;
  logic            in_ready_reg;
  logic [C_DW-1:0] out_data_reg;
  logic [C_DW-1:0] skid_data_reg;
  logic            push;
  logic            out_free;
  logic            skid_valid_next;

  assign push     = out_valid_reg & ~wr_full;
  assign out_free = ~out_valid_reg | push;

  // in_valid can only arrive while the skid entry is empty, because in_ready mirrors it.
  always_comb begin
    skid_valid_next = skid_valid_reg;
    if (out_free)
      skid_valid_next = 1'b0;
    else if (in_valid)
      skid_valid_next = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b0;
      out_data_reg   <= '0;
      skid_data_reg  <= '0;
    end else begin
      skid_valid_reg <= skid_valid_next;
      in_ready_reg   <= ~skid_valid_next;
      if (out_free) begin
        if (skid_valid_reg) begin
          out_data_reg  <= skid_data_reg;
          out_valid_reg <= 1'b1;
        end else if (in_valid) begin
          out_data_reg  <= in_data;
          out_valid_reg <= 1'b1;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end else if (in_valid) begin
        skid_data_reg <= in_data;
      end
    end
  end

  assign in_ready = in_ready_reg;
  assign wr_en    = push;
  assign wr_data  = out_data_reg;

endmodule

// File: rtl/fifo_frame_writer.sv
// Frame-aware write front end for the async FIFO: truncates frames longer than C_MAX_LEN.
// Optional macro FIFO_FRAME_WR_STATS_EN enables the frame / truncation counters.
module fifo_frame_writer
  import fifo_frame_writer_pkg::*;
#(
  parameter int C_WIDTH   = 32,
  parameter int C_MAX_LEN = 1518
) (
  input  logic                CLK,
  input  logic                RST_N,
  fifo_frame_writer_if.slave  s_if,
  fifo_wr_port_if.master      wr_if,
  output logic                TRUNC_ERR,
  output logic [31:0]         STAT_FRAMES,
  output logic [31:0]         STAT_TRUNC
);

  localparam int C_LEN_BITS = clog2(C_MAX_LEN + 1);

  wr_state_e             state_reg;
  logic [C_LEN_BITS-1:0] len_reg;
  logic                  trunc_err_reg;
  logic                  accept;
  logic                  at_limit;
  logic                  keep;
  logic                  skid_in_valid;
  logic [C_WIDTH:0]      skid_in_data;

  assign accept   = s_if.S_VALID & s_if.S_READY;
  // The incoming word is the C_MAX_LEN-th of its frame: it must close the frame either way.
  assign at_limit = (state_reg == FRAME) && (len_reg == C_LEN_BITS'(C_MAX_LEN - 1));
  assign keep     = (state_reg != TRUNC);

  assign skid_in_valid = accept & keep;
  assign skid_in_data  = {s_if.S_LAST | at_limit, s_if.S_DATA};

  fifo_wr_skid #(
    .C_DW (C_WIDTH + 1)
  ) u_skid (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .in_valid (skid_in_valid),
    .in_data  (skid_in_data),
    .in_ready (s_if.S_READY),
    .wr_en    (wr_if.WR_EN),
    .wr_data  (wr_if.WR_DATA),
    .wr_full  (wr_if.WR_FULL)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      trunc_err_reg <= 1'b0;
    end else begin
      trunc_err_reg <= 1'b0;
      if (accept) begin
        case (state_reg)
          IDLE: begin
            if (!s_if.S_LAST) begin
              len_reg   <= C_LEN_BITS'(1);
              state_reg <= FRAME;
            end
          end
          FRAME: begin
            if (at_limit && !s_if.S_LAST) begin
              len_reg       <= '0;
              trunc_err_reg <= 1'b1;
              state_reg     <= TRUNC;
            end else if (s_if.S_LAST) begin
              len_reg   <= '0;
              state_reg <= IDLE;
            end else begin
              len_reg <= len_reg + C_LEN_BITS'(1);
            end
          end
          TRUNC: begin
            if (s_if.S_LAST) begin
              len_reg   <= '0;
              state_reg <= IDLE;
            end
          end
          default: begin
            len_reg   <= '0;
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign TRUNC_ERR = trunc_err_reg;

`ifdef FIFO_FRAME_WR_STATS_EN
  logic [31:0] stat_frames_reg;
  logic [31:0] stat_trunc_reg;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stat_frames_reg <= '0;
      stat_trunc_reg  <= '0;
    end else begin
      if (wr_if.WR_EN && wr_if.WR_DATA[C_WIDTH])
        stat_frames_reg <= stat_frames_reg + 32'd1;
      if (trunc_err_reg)
        stat_trunc_reg <= stat_trunc_reg + 32'd1;
    end
  end

  assign STAT_FRAMES = stat_frames_reg;
  assign STAT_TRUNC  = stat_trunc_reg;
`else
  assign STAT_FRAMES = 32'd0;
  assign STAT_TRUNC  = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Self-checking bench for fifo_frame_writer: random frames against a frame-level model
// (keep the first C_MAX_LEN words, close the frame early when it is too long).
module tb_fifo_frame_writer;

  localparam int W   = 16;
  localparam int MAX = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        trunc_err;
  logic [31:0] stat_frames;
  logic [31:0] stat_trunc;

  fifo_frame_writer_if #(.C_WIDTH(W)) s_if ();
  fifo_wr_port_if      #(.C_WIDTH(W)) wr_if ();

  fifo_frame_writer #(
    .C_WIDTH   (W),
    .C_MAX_LEN (MAX)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .s_if        (s_if),
    .wr_if       (wr_if),
    .TRUNC_ERR   (trunc_err),
    .STAT_FRAMES (stat_frames),
    .STAT_TRUNC  (stat_trunc)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [W:0] exp_q[$];
  logic [W:0] obs_q[$];
  int         acc_cyc_q[$];
  int         obs_cyc_q[$];
  int         exp_trunc = 0;
  int         exp_frames = 0;
  int         trunc_seen = 0;
  logic       prev_trunc = 1'b0;
  bit         rnd_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: collects pushed words, polices WR_EN under full and the pulse width.
  always @(negedge clk) begin
    if (wr_if.WR_EN === 1'b1) begin
      obs_q.push_back(wr_if.WR_DATA);
      obs_cyc_q.push_back(cyc);
    end
    if (wr_if.WR_FULL === 1'b1) begin
      checks++;
      if (wr_if.WR_EN !== 1'b0) begin
        failures++;
        $display("FAIL wr_en_while_full: WR_EN=%b required 0 (cycle %0d)", wr_if.WR_EN, cyc);
      end
    end
    if (trunc_err === 1'b1) begin
      trunc_seen++;
      checks++;
      if (prev_trunc === 1'b1) begin
        failures++;
        $display("FAIL trunc_pulse_width: TRUNC_ERR high 2 cycles in a row (cycle %0d)", cyc);
      end
    end
    prev_trunc = trunc_err;
  end

  function automatic int sf_exp();
`ifdef FIFO_FRAME_WR_STATS_EN
    return exp_frames;
`else
    return 0;
`endif
  endfunction

  function automatic int st_exp();
`ifdef FIFO_FRAME_WR_STATS_EN
    return exp_trunc;
`else
    return 0;
`endif
  endfunction

  // Called shortly after a posedge; returns shortly after the posedge that accepted the word.
  task automatic send_word(input logic [W-1:0] d, input logic l);
    int n;
    n = 0;
    s_if.S_DATA  = d;
    s_if.S_LAST  = l;
    s_if.S_VALID = 1'b1;
    @(negedge clk);
    while (s_if.S_READY !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: S_READY=%b required 1 within 200 cycles", s_if.S_READY);
    end else begin
      acc_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    s_if.S_VALID = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit gaps);
    logic [W-1:0] d;
    logic         l;
    for (int i = 0; i < len; i++) begin
      d = W'($urandom);
      l = (i == len - 1);
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
      end
      send_word(d, l);
      if (i < MAX) begin
        exp_q.push_back({l || (i == MAX - 1), d});
        if (l || i == MAX - 1) exp_frames++;
      end
    end
    if (len > MAX) exp_trunc++;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (n >= 3 && obs_q.size() >= exp_q.size()) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    exp_q.delete();
    obs_q.delete();
    acc_cyc_q.delete();
    obs_cyc_q.delete();
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    wr_if.WR_FULL  = 1'b0;
    s_if.S_VALID   = 1'b1;
    s_if.S_LAST    = 1'b0;
    s_if.S_DATA    = W'($urandom);
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      checks += 2;
      if (wr_if.WR_EN !== 1'b0) begin
        failures++;
        $display("FAIL reset_wr_en: WR_EN=%b required 0", wr_if.WR_EN);
      end
      if (s_if.S_READY !== 1'b0) begin
        failures++;
        $display("FAIL reset_s_ready: S_READY=%b required 0", s_if.S_READY);
      end
      @(posedge clk);
    end
    #1;
    rst_n        = 1'b1;
    s_if.S_VALID = 1'b0;
    @(negedge clk);
    checks += 5;
    if (s_if.S_READY !== 1'b0) begin
      failures++;
      $display("FAIL ready_release_c1: S_READY=%b required 0", s_if.S_READY);
    end
    if (wr_if.WR_DATA !== '0) begin
      failures++;
      $display("FAIL reset_wr_data: WR_DATA=%h required 0", wr_if.WR_DATA);
    end
    if (trunc_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_trunc_err: TRUNC_ERR=%b required 0", trunc_err);
    end
    if (stat_frames !== 32'd0) begin
      failures++;
      $display("FAIL reset_stat_frames: STAT_FRAMES=%0d required 0", stat_frames);
    end
    if (stat_trunc !== 32'd0) begin
      failures++;
      $display("FAIL reset_stat_trunc: STAT_TRUNC=%0d required 0", stat_trunc);
    end
    @(negedge clk);
    checks++;
    if (s_if.S_READY !== 1'b1) begin
      failures++;
      $display("FAIL ready_release_c2: S_READY=%b required 1", s_if.S_READY);
    end
    @(posedge clk);
    #1;
    clear_queues();
  endtask

  task automatic test_stream();
    bit ok;
    send_frame(4, 1'b0);
    wait_drain(ok);
    checks++;
    if (!ok || obs_q.size() != 4) begin
      failures++;
      $display("FAIL stream_count: got %0d words required 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks += 3;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL stream_word%0d: got %h required %h", i, obs_q[i], exp_q[i]);
        end
        if (obs_cyc_q[i] != acc_cyc_q[i] + 1) begin
          failures++;
          $display("FAIL stream_latency%0d: write cycle %0d required %0d", i, obs_cyc_q[i], acc_cyc_q[i] + 1);
        end
        if (obs_cyc_q[i] != obs_cyc_q[0] + i) begin
          failures++;
          $display("FAIL stream_consecutive%0d: write cycle %0d required %0d", i, obs_cyc_q[i], obs_cyc_q[0] + i);
        end
      end
    end
    checks++;
    if (stat_frames !== 32'(sf_exp())) begin
      failures++;
      $display("FAIL stream_stat_frames: STAT_FRAMES=%0d required %0d", stat_frames, sf_exp());
    end
    clear_queues();
  endtask

  task automatic test_backpressure();
    bit ok;
    wr_if.WR_FULL = 1'b1;
    fork
      send_frame(5, 1'b0);
      begin
        for (int k = 1; k <= 5; k++) begin
          @(negedge clk);
          if (k >= 2) begin
            checks++;
            if (wr_if.WR_DATA !== exp_q[0]) begin
              failures++;
              $display("FAIL bp_hold%0d: WR_DATA=%h required %h", k, wr_if.WR_DATA, exp_q[0]);
            end
          end
        end
        checks += 2;
        if (acc_cyc_q.size() != 2) begin
          failures++;
          $display("FAIL bp_buffered: accepted %0d words required 2", acc_cyc_q.size());
        end
        if (s_if.S_READY !== 1'b0) begin
          failures++;
          $display("FAIL bp_ready: S_READY=%b required 0", s_if.S_READY);
        end
        @(posedge clk);
        #1;
        wr_if.WR_FULL = 1'b0;
      end
    join
    wait_drain(ok);
    checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bp_count: got %0d words required %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL bp_word%0d: got %h required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    clear_queues();
  endtask

  task automatic test_truncation();
    bit ok;
    send_frame(7, 1'b0);
    send_frame(3, 1'b0);
    wait_drain(ok);
    checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL trunc_count: got %0d words required %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL trunc_word%0d: got %h required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks += 2;
    if (trunc_seen != exp_trunc) begin
      failures++;
      $display("FAIL trunc_pulses: got %0d pulses required %0d", trunc_seen, exp_trunc);
    end
    if (stat_trunc !== 32'(st_exp())) begin
      failures++;
      $display("FAIL trunc_stat: STAT_TRUNC=%0d required %0d", stat_trunc, st_exp());
    end
    clear_queues();
  endtask

  task automatic test_back_to_back();
    bit ok;
    send_frame(MAX, 1'b0);
    repeat (5) send_frame(1, 1'b0);
    wait_drain(ok);
    checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL b2b_count: got %0d words required %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL b2b_word%0d: got %h required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks += 2;
    if (trunc_seen != exp_trunc) begin
      failures++;
      $display("FAIL b2b_no_trunc: got %0d pulses required %0d", trunc_seen, exp_trunc);
    end
    if (stat_frames !== 32'(sf_exp())) begin
      failures++;
      $display("FAIL b2b_stat_frames: STAT_FRAMES=%0d required %0d", stat_frames, sf_exp());
    end
    clear_queues();
  endtask

  task automatic test_random();
    bit ok;
    rnd_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 14; f++) send_frame($urandom_range(1, 9), 1'b1);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          wr_if.WR_FULL = ($urandom_range(0, 2) == 0);
        end
        wr_if.WR_FULL = 1'b0;
      end
    join
    wait_drain(ok);
    checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rand_count: got %0d words required %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rand_word%0d: got %h required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks += 3;
    if (trunc_seen != exp_trunc) begin
      failures++;
      $display("FAIL rand_trunc: got %0d pulses required %0d", trunc_seen, exp_trunc);
    end
    if (stat_frames !== 32'(sf_exp())) begin
      failures++;
      $display("FAIL rand_stat_frames: STAT_FRAMES=%0d required %0d", stat_frames, sf_exp());
    end
    if (stat_trunc !== 32'(st_exp())) begin
      failures++;
      $display("FAIL rand_stat_trunc: STAT_TRUNC=%0d required %0d", stat_trunc, st_exp());
    end
    clear_queues();
  endtask

  task automatic test_mid_reset();
    bit ok;
    wr_if.WR_FULL = 1'b1;
    send_word(W'($urandom), 1'b0);
    send_word(W'($urandom), 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    wr_if.WR_FULL = 1'b0;
    @(negedge clk);
    checks += 2;
    if (wr_if.WR_EN !== 1'b0) begin
      failures++;
      $display("FAIL midrst_wr_en: WR_EN=%b required 0", wr_if.WR_EN);
    end
    if (s_if.S_READY !== 1'b0) begin
      failures++;
      $display("FAIL midrst_ready: S_READY=%b required 0", s_if.S_READY);
    end
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    clear_queues();
    exp_frames = 0;
    exp_trunc  = 0;
    trunc_seen = 0;
    send_frame(MAX, 1'b0);
    wait_drain(ok);
    checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL midrst_count: got %0d words required %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL midrst_word%0d: got %h required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks += 2;
    if (trunc_seen != 0) begin
      failures++;
      $display("FAIL midrst_trunc: got %0d pulses required 0", trunc_seen);
    end
    if (stat_frames !== 32'(sf_exp())) begin
      failures++;
      $display("FAIL midrst_stat_frames: STAT_FRAMES=%0d required %0d", stat_frames, sf_exp());
    end
    clear_queues();
  endtask

  initial begin
    s_if.S_VALID  = 1'b0;
    s_if.S_LAST   = 1'b0;
    s_if.S_DATA   = '0;
    wr_if.WR_FULL = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_truncation();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
